// File: rtl/fifo_level_module.sv
// Synchronous first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty levels, sticky overflow/underflow flags and flush.
module fifo_level_module #(
  parameter int NB_FIFOMODULE_DATA = 8,
  parameter int NB_FIFOMODULE_ADDR = 4,
  parameter int AFULL_MARGIN       = 2,
  parameter int AEMPTY_MARGIN      = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_fifomodule_FLUSH,
  input  logic                          i_fifomodule_CLRFLAGS,
  input  logic                          i_fifomodule_WRITE,
  input  logic [NB_FIFOMODULE_DATA-1:0] i_fifomodule_WRITEDATA,
  input  logic                          i_fifomodule_READ,
  output logic [NB_FIFOMODULE_DATA-1:0] o_fifomodule_READATA,
  output logic                          o_fifomodule_EMPTY,
  output logic                          o_fifomodule_FULL,
  output logic                          o_fifomodule_AFULL,
  output logic                          o_fifomodule_AEMPTY,
  output logic [NB_FIFOMODULE_ADDR:0]   o_fifomodule_COUNT,
  output logic                          o_fifomodule_OVERFLOW,
  output logic                          o_fifomodule_UNDERFLOW
);

  localparam int DEPTH  = 2 ** NB_FIFOMODULE_ADDR;
  localparam int NB_CNT = NB_FIFOMODULE_ADDR + 1;

  localparam logic [NB_CNT-1:0]             FULL_LVL   = NB_CNT'(DEPTH);
  localparam logic [NB_CNT-1:0]             AFULL_LVL  = NB_CNT'(DEPTH - AFULL_MARGIN);
  localparam logic [NB_CNT-1:0]             AEMPTY_LVL = NB_CNT'(AEMPTY_MARGIN);
  localparam logic [NB_CNT-1:0]             CNT_ONE    = NB_CNT'(1);
  localparam logic [NB_FIFOMODULE_ADDR-1:0] PTR_ONE    = NB_FIFOMODULE_ADDR'(1);

  logic [NB_FIFOMODULE_DATA-1:0] mem_q [DEPTH];

  logic [NB_FIFOMODULE_ADDR-1:0] wptr_q, wptr_d;
  logic [NB_FIFOMODULE_ADDR-1:0] rptr_q, rptr_d;
  logic [NB_CNT-1:0]             count_q, count_d;
  logic                          overflow_q, overflow_d;
  logic                          underflow_q, underflow_d;

  logic empty;
  logic full;
  logic rd_ok;
  logic wr_ok;

  // Status is decoded only from the registered count, so it never depends on inputs.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_LVL);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latches are inferred.
    rd_ok       = 1'b0;
    wr_ok       = 1'b0;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (i_fifomodule_FLUSH) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      rd_ok = i_fifomodule_READ & ~empty;
      // A write into a full FIFO is only legal when a pop frees a slot this cycle.
      wr_ok = i_fifomodule_WRITE & (~full | rd_ok);

      if (wr_ok) wptr_d = wptr_q + PTR_ONE;
      if (rd_ok) rptr_d = rptr_q + PTR_ONE;

      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      // A new error event outranks a clear issued in the same cycle.
      if (i_fifomodule_WRITE && !wr_ok)  overflow_d = 1'b1;
      else if (i_fifomodule_CLRFLAGS)    overflow_d = 1'b0;

      if (i_fifomodule_READ && !rd_ok)   underflow_d = 1'b1;
      else if (i_fifomodule_CLRFLAGS)    underflow_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every use of its contents.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem_q[wptr_q] <= i_fifomodule_WRITEDATA;
  end

  assign o_fifomodule_READATA   = mem_q[rptr_q];
  assign o_fifomodule_EMPTY     = empty;
  assign o_fifomodule_FULL      = full;
  assign o_fifomodule_AFULL     = (count_q >= AFULL_LVL);
  assign o_fifomodule_AEMPTY    = (count_q <= AEMPTY_LVL);
  assign o_fifomodule_COUNT     = count_q;
  assign o_fifomodule_OVERFLOW  = overflow_q;
  assign o_fifomodule_UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_fifo_level_module.sv
// Directed bench for fifo_level_module: fill/drain, boundary read+write,
// wrap-around with a queue scoreboard, flush/clear-flag priority, async reset.
module tb_fifo_level_module;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       clr;
  logic       wr;
  logic [7:0] wdata;
  logic       rd;
  logic [7:0] rdata;
  logic       empty;
  logic       full;
  logic       afull;
  logic       aempty;
  logic [4:0] count;
  logic       ovf;
  logic       unf;

  int checks   = 0;
  int failures = 0;

  fifo_level_module #(
    .NB_FIFOMODULE_DATA(8),
    .NB_FIFOMODULE_ADDR(4),
    .AFULL_MARGIN(2),
    .AEMPTY_MARGIN(2)
  ) dut (
    .i_clk                 (clk),
    .i_reset               (rst),
    .i_fifomodule_FLUSH    (flush),
    .i_fifomodule_CLRFLAGS (clr),
    .i_fifomodule_WRITE    (wr),
    .i_fifomodule_WRITEDATA(wdata),
    .i_fifomodule_READ     (rd),
    .o_fifomodule_READATA  (rdata),
    .o_fifomodule_EMPTY    (empty),
    .o_fifomodule_FULL     (full),
    .o_fifomodule_AFULL    (afull),
    .o_fifomodule_AEMPTY   (aempty),
    .o_fifomodule_COUNT    (count),
    .o_fifomodule_OVERFLOW (ovf),
    .o_fifomodule_UNDERFLOW(unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of requests, let the edge take them, settle 1ns past it.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    wr = w; wdata = d; rd = r; flush = f; clr = c;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
    #3;
    checks += 7;
    if (empty  !== 1'b1)  begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (full   !== 1'b0)  begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    if (afull  !== 1'b0)  begin failures++; $display("FAIL reset_afull got=%b exp=0", afull); end
    if (aempty !== 1'b1)  begin failures++; $display("FAIL reset_aempty got=%b exp=1", aempty); end
    if (count  !== 5'd0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (ovf    !== 1'b0)  begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    if (unf    !== 1'b0)  begin failures++; $display("FAIL reset_unf got=%b exp=0", unf); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checks += 3;
      if (count  !== 5'(i))     begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      if (afull  !== (i >= 14)) begin failures++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, afull, i >= 14); end
      if (aempty !== (i <= 2))  begin failures++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", i, aempty, i <= 2); end
    end
    checks++;
    if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    checks += 3;
    if (ovf   !== 1'b1)  begin failures++; $display("FAIL overflow_flag got=%b exp=1", ovf); end
    if (count !== 5'd16) begin failures++; $display("FAIL overflow_count got=%0d exp=16", count); end
    if (full  !== 1'b1)  begin failures++; $display("FAIL overflow_full got=%b exp=1", full); end
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (rdata !== 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, rdata, 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks += 3;
    if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    if (count !== 5'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
    if (unf   !== 1'b0) begin failures++; $display("FAIL drain_unf got=%b exp=0", unf); end
  endtask

  task automatic test_rw_empty();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL clrflags_ovf got=%b exp=0", ovf); end
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    checks += 4;
    if (unf   !== 1'b1)  begin failures++; $display("FAIL rw_empty_unf got=%b exp=1", unf); end
    if (count !== 5'd1)  begin failures++; $display("FAIL rw_empty_count got=%0d exp=1", count); end
    if (rdata !== 8'h5A) begin failures++; $display("FAIL rw_empty_data got=%h exp=5a", rdata); end
    if (empty !== 1'b0)  begin failures++; $display("FAIL rw_empty_empty got=%b exp=0", empty); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checks += 2;
    if (count !== 5'd0) begin failures++; $display("FAIL rw_empty_pop got=%0d exp=0", count); end
    if (unf   !== 1'b0) begin failures++; $display("FAIL rw_empty_clr got=%b exp=0", unf); end
  endtask

  task automatic test_rw_full();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    checks += 4;
    if (count !== 5'd16) begin failures++; $display("FAIL rw_full_count got=%0d exp=16", count); end
    if (full  !== 1'b1)  begin failures++; $display("FAIL rw_full_full got=%b exp=1", full); end
    if (ovf   !== 1'b0)  begin failures++; $display("FAIL rw_full_ovf got=%b exp=0", ovf); end
    if (rdata !== 8'h21) begin failures++; $display("FAIL rw_full_head got=%h exp=21", rdata); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 15) ? 8'(8'h21 + i) : 8'h77;
      checks++;
      if (rdata !== exp_d) begin failures++; $display("FAIL rw_full_drain[%0d] got=%h exp=%h", i, rdata, exp_d); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL rw_full_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] d;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 3; k++) begin
        d = 8'($urandom);
        q.push_back(d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
        checks += 3;
        if (count  !== 5'(q.size()))   begin failures++; $display("FAIL wrap_wcount got=%0d exp=%0d", count, q.size()); end
        if (afull  !== (q.size() >= 14)) begin failures++; $display("FAIL wrap_afull got=%b exp=%b", afull, q.size() >= 14); end
        if (aempty !== (q.size() <= 2))  begin failures++; $display("FAIL wrap_aempty got=%b exp=%b", aempty, q.size() <= 2); end
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rdata !== q[0]) begin failures++; $display("FAIL wrap_data got=%h exp=%h", rdata, q[0]); end
        void'(q.pop_front());
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (count  !== 5'(q.size()))   begin failures++; $display("FAIL wrap_rcount got=%0d exp=%0d", count, q.size()); end
        if (aempty !== (q.size() <= 2))  begin failures++; $display("FAIL wrap_raempty got=%b exp=%b", aempty, q.size() <= 2); end
      end
    end
    while (q.size() > 0) begin
      checks++;
      if (rdata !== q[0]) begin failures++; $display("FAIL wrap_tail got=%h exp=%h", rdata, q[0]); end
      void'(q.pop_front());
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (count !== 5'd8) begin failures++; $display("FAIL flush_pre_count got=%0d exp=8", count); end
    if (ovf   !== 1'b1) begin failures++; $display("FAIL flush_pre_ovf got=%b exp=1", ovf); end
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    checks += 4;
    if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty); end
    if (ovf   !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", ovf); end
    if (unf   !== 1'b0) begin failures++; $display("FAIL flush_unf got=%b exp=0", unf); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++;
    if (unf !== 1'b1) begin failures++; $display("FAIL clr_vs_set_unf got=%b exp=1", unf); end
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checks += 2;
    if (unf   !== 1'b0) begin failures++; $display("FAIL flush_read_unf got=%b exp=0", unf); end
    if (count !== 5'd0) begin failures++; $display("FAIL flush_read_count got=%0d exp=0", count); end
  endtask

  task automatic test_async_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (count !== 5'd5) begin failures++; $display("FAIL areset_pre_count got=%0d exp=5", count); end
    if (unf   !== 1'b1) begin failures++; $display("FAIL areset_pre_unf got=%b exp=1", unf); end
    #3 rst = 1'b1;
    #1;
    checks += 5;
    if (count  !== 5'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
    if (empty  !== 1'b1) begin failures++; $display("FAIL areset_empty got=%b exp=1", empty); end
    if (aempty !== 1'b1) begin failures++; $display("FAIL areset_aempty got=%b exp=1", aempty); end
    if (unf    !== 1'b0) begin failures++; $display("FAIL areset_unf got=%b exp=0", unf); end
    if (full   !== 1'b0) begin failures++; $display("FAIL areset_full got=%b exp=0", full); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (rdata !== 8'h3C) begin failures++; $display("FAIL post_reset_data got=%h exp=3c", rdata); end
    if (count !== 5'd1)  begin failures++; $display("FAIL post_reset_count got=%0d exp=1", count); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL post_reset_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_rw_empty();
    test_rw_full();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
